sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit, 12-pin seven-segment display on the debug board.
//  Holds a 16-bit hex value (4 nibbles plus 4 decimal points) and cycles through the digits.
//  For each digit: drives the common pin, feeds the nibble through the sevenseg decoder, and inserts dead time.
//  Sits between the CPU debug/status logic (value producer) and the display pins.
//  Display updates are tear-free: a new value is applied only at a frame boundary.
// PARAMETERS
//  REFRESH_DIV   16'd50000  clk cycles each digit is lit (>=1)
//  BLANK_CYCLES  16'd16     clk cycles with all commons off between digits, for ghosting (>=1)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  val_valid   in   1   producer has a new display value
//  val_ready   out  1   controller can accept a value (pending slot empty)
//  val_data    in   16  nibble k = digit k; digit0 is rightmost
//  val_dp      in   4   decimal point per digit, 1 = lit
//  dig_en      in   4   per-digit enable; a disabled digit keeps its slot but stays dark
//  lz_suppress in   1   blank leading zero digits
//  pins        out  12  display pin drive, pins[n-1] = datasheet pin n (1-indexed)
//  frame_done  out  1   one-cycle pulse when the digit3 slot ends
// BEHAVIOUR
//  Pin map:
//   - Segments live at pin indices 10,9,6,4,3,1,0 (SEG_MASK 12'h65B); 1 = lit.
//   - DP is at index 2.
//   - Commons are active-low: digit3 = idx11, digit2 = idx8, digit1 = idx7, digit0 = idx5; 1 = off.
//   - DARK = 12'h9A0 (all commons off, no segments).
//  Reset (async, same edge):
//   - pins = DARK; state = BLANK; digit index = 0; counters = 0.
//   - Shadow value/dp = 0; pending slot empty; frame_done = 0.
//   - val_ready = 0 while reset is high, 1 from the first cycle after release.
//  FSM:
//   - BLANK: pins = DARK for BLANK_CYCLES cycles, then go to DRIVE.
//   - DRIVE: pins = pattern for the current digit for REFRESH_DIV cycles, then go to BLANK with idx = idx+1 mod 4.
//  Pattern:
//   - (decode(nibble) & SEG_MASK) | (dp << 2) | commons, with only the current digit's common cleared.
//   - Sent as DARK instead if dig_en[idx] = 0 or the digit is lz-suppressed.
//  Timing:
//   - pins is registered and changes on the cycle the state is entered.
//   - Digit period = BLANK_CYCLES + REFRESH_DIV; frame = 4 digit periods.
//  Leading-zero suppression:
//   - With lz_suppress = 1, scan digits 3..1 from the top; a digit is suppressed while it and every higher digit are 0.
//   - Digit0 is never suppressed.
//   - Suppression is computed from the shadow value.
//  Handshake:
//   - val_ready = !pending_full.
//   - On val_valid & val_ready, val_data/val_dp are captured into pending and pending_full is set.
//   - val_valid without ready is ignored; the producer holds.
//  Frame boundary = the cycle BLANK is entered with idx = 0:
//   - If pending_full: shadow <= pending and pending_full clears, so val_ready rises the next cycle.
//   - A value accepted on the boundary cycle itself waits for the following frame.
//  frame_done: asserted for exactly 1 cycle, on the DRIVE->BLANK transition out of idx = 3.
//  Counters: width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)) + 1; they count from 0 to param-1 and reload on each state change.
//  Inputs dig_en and lz_suppress are sampled live every cycle.
// STRUCTURE
//  Shared package/header sevenseg_pkg: SEG_MASK, DP_IDX, COM_IDX[0..3], DARK, state encodings (BLANK = 0, DRIVE = 1).
//  Sub-module: one existing sevenseg decoder, fed by a mux of shadow nibble[idx].
//  The decoder's 12-bit output is masked with SEG_MASK before it is merged.
// TESTING (REFRESH_DIV = 4, BLANK_CYCLES = 2)
//  1. Reset pulse mid-run -> pins = 12'h9A0 immediately, val_ready = 0 during reset and 1 after; first slot is BLANK, digit0.
//  2. Load 16'h1234, dp = 0, dig_en = 4'hF -> from the next boundary, each digit is lit for 4 cycles.
//     - digit0 slot: pins = 12'hBD8.
//     - Each slot is preceded by 2 cycles of 12'h9A0.
//     - frame_done pulses every 24 cycles.
//  3. lz_suppress = 1, load 16'h0007 -> digit3..1 slots = 12'h9A0, digit0 slot = 12'hFC8.
//     - Load 16'h0100 -> digit2 and digit1 lit, digit3 dark, digit0 shows '0'.
//  4. Back-to-back loads of 16'hAAAA then 16'h5555 mid-frame -> second load stalls (val_ready = 0) until the boundary.
//     - No frame ever mixes nibbles of two values.
//  5. val_dp = 4'b0001, dig_en = 4'b1110 -> digit0 slot stays 12'h9A0 with dp suppressed; slot timing is unchanged.
//  6. Load 16'h000B, lz off -> digit0 slot = (12'h01B | 12'h980) = 12'h99B; digits 3..1 show '0' (12'h64B with their commons).

Source files
------------

// File: rtl/sevenseg_pkg.sv
//==============================================================================
// Module  : sevenseg_pkg
// Brief   : Shared pin map, FSM states and leading-zero helper for the
//           seven-segment scan controller.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package sevenseg_pkg;

    localparam logic [11:0]      SEG_MASK = 12'h65B;
    localparam int               DP_IDX   = 2;
    // Common pin index per digit; element 0 is digit0 (rightmost).
    localparam logic [3:0][3:0]  COM_IDX  = {4'd11, 4'd8, 4'd7, 4'd5};
    localparam logic [11:0]      DARK     = 12'h9A0;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Digit k is blanked while it and every digit above it are zero; digit0 always shows.
    function automatic logic [3:0] lz_blank(input logic [15:0] v);
        logic [3:0] s;
        s[3] = (v[15:12] == 4'h0);
        s[2] = s[3] & (v[11:8] == 4'h0);
        s[1] = s[2] & (v[7:4] == 4'h0);
        s[0] = 1'b0;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_decoder.sv
//==============================================================================
// Module  : sevenseg_decoder
// Brief   : Hex nibble to seven-segment pattern, already laid out on pin indices.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sevenseg_decoder (
    input  logic [3:0]  nibble,
    output logic [11:0] seg
);

    // Segment pins: a=10 b=9 c=6 d=1 e=0 f=3 g=4
    always_comb begin
        seg = 12'h000;
        case (nibble)
            4'h0:    seg = 12'h64B;
            4'h1:    seg = 12'h240;
            4'h2:    seg = 12'h613;
            4'h3:    seg = 12'h652;
            4'h4:    seg = 12'h258;
            4'h5:    seg = 12'h45A;
            4'h6:    seg = 12'h45B;
            4'h7:    seg = 12'h648;
            4'h8:    seg = 12'h65B;
            4'h9:    seg = 12'h65A;
            4'hA:    seg = 12'h659;
            4'hB:    seg = 12'h01B;
            4'hC:    seg = 12'h40B;
            4'hD:    seg = 12'h253;
            4'hE:    seg = 12'h41B;
            default: seg = 12'h419;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
//==============================================================================
// Module  : sevenseg_scan_ctrl
// Brief   : 4-digit multiplexed seven-segment scanner with dead time and
//           tear-free value updates at frame boundaries.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        val_valid,
    output logic        val_ready,
    input  logic [15:0] val_data,
    input  logic [3:0]  val_dp,
    input  logic [3:0]  dig_en,
    input  logic        lz_suppress,
    output logic [11:0] pins,
    output logic        frame_done
);

    localparam int             RD      = int'(REFRESH_DIV);
    localparam int             BC      = int'(BLANK_CYCLES);
    localparam int             CW      = $clog2((RD > BC) ? RD : BC) + 1;
    localparam logic [CW-1:0]  RD_LAST = CW'(RD - 1);
    localparam logic [CW-1:0]  BC_LAST = CW'(BC - 1);

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_shadow;
    logic [3:0]     r_shadow_dp;
    logic [15:0]    r_pend_data;
    logic [3:0]     r_pend_dp;
    logic           r_pend_full;

    logic           w_accept;
    logic           w_boundary;
    logic [15:0]    w_shadow_nxt;
    logic [3:0]     w_dp_nxt;
    logic [3:0]     w_nibble;
    logic [11:0]    w_dec;
    logic [3:0]     w_lz;
    logic [11:0]    w_pattern;

    assign val_ready  = ~r_pend_full & ~reset;
    assign w_accept   = val_valid & val_ready;
    assign w_boundary = (r_state == BLANK) && (r_idx == 2'd0) && (r_cnt == '0);

    // Pattern is built from the post-swap value so a 1-cycle blank slot cannot tear.
    assign w_shadow_nxt = (w_boundary && r_pend_full) ? r_pend_data : r_shadow;
    assign w_dp_nxt     = (w_boundary && r_pend_full) ? r_pend_dp   : r_shadow_dp;
    assign w_nibble     = w_shadow_nxt[{r_idx, 2'b00} +: 4];
    assign w_lz         = lz_suppress ? lz_blank(w_shadow_nxt) : 4'h0;

    sevenseg_decoder u_decoder (
        .nibble (w_nibble),
        .seg    (w_dec)
    );

    always_comb begin
        w_pattern = DARK;
        if (dig_en[r_idx] && !w_lz[r_idx]) begin
            w_pattern = (w_dec & SEG_MASK) | (12'(w_dp_nxt[r_idx]) << DP_IDX)
                      | (DARK & ~(12'd1 << COM_IDX[r_idx]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= BLANK;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            pins        <= DARK;
            frame_done  <= 1'b0;
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_pend_data <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_pend_full <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (w_boundary && r_pend_full) begin
                r_shadow    <= r_pend_data;
                r_shadow_dp <= r_pend_dp;
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pend_data <= val_data;
                r_pend_dp   <= val_dp;
                r_pend_full <= 1'b1;
            end

            case (r_state)
                BLANK: begin
                    if (r_cnt == BC_LAST) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                        pins    <= w_pattern;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (r_cnt == RD_LAST) begin
                        r_state    <= BLANK;
                        r_cnt      <= '0;
                        r_idx      <= r_idx + 2'd1;
                        pins       <= DARK;
                        frame_done <= (r_idx == 2'd3);
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        pins       <= w_pattern;
                    end
                end
                default: begin
                    r_state <= BLANK;
                    r_cnt   <= '0;
                    pins    <= DARK;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
//==============================================================================
// Module  : tb_sevenseg_scan_ctrl
// Brief   : Self-checking bench for sevenseg_scan_ctrl (REFRESH_DIV=4, BLANK_CYCLES=2).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sevenseg_scan_ctrl;

    localparam int          BC        = 2;
    localparam int          SLOT      = 6;
    localparam int          FRAME     = 24;
    localparam logic [11:0] DARK_PINS = 12'h9A0;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        val_valid   = 1'b0;
    logic        val_ready;
    logic [15:0] val_data    = 16'h0000;
    logic [3:0]  val_dp      = 4'h0;
    logic [3:0]  dig_en      = 4'hF;
    logic        lz_suppress = 1'b0;
    logic [11:0] pins;
    logic        frame_done;

    sevenseg_scan_ctrl #(
        .REFRESH_DIV  (16'd4),
        .BLANK_CYCLES (16'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .val_valid   (val_valid),
        .val_ready   (val_ready),
        .val_data    (val_data),
        .val_dp      (val_dp),
        .dig_en      (dig_en),
        .lz_suppress (lz_suppress),
        .pins        (pins),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: segment shapes by letter, datasheet common pins per digit.
    string SHAPES [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abcf",
                           "abcdefg", "abcdfg", "abcefg", "defg", "adef", "bcdeg", "adefg", "aefg"};
    int    COM_PIN [4] = '{6, 8, 9, 12};

    function automatic logic [11:0] seg_pins(input logic [3:0] n);
        logic [11:0] p;
        string s;
        p = '0;
        s = SHAPES[n];
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": p[10] = 1'b1;
                "b": p[9]  = 1'b1;
                "c": p[6]  = 1'b1;
                "d": p[1]  = 1'b1;
                "e": p[0]  = 1'b1;
                "f": p[3]  = 1'b1;
                "g": p[4]  = 1'b1;
                default: p = p;
            endcase
        end
        return p;
    endfunction

    int          m_ph;
    logic [15:0] m_sh, m_pd;
    logic [3:0]  m_sdp, m_pdp;
    bit          m_pf;
    logic [11:0] m_ep;
    bit          m_efd;

    function automatic logic [11:0] model_pins(input int ph);
        int          k;
        logic [11:0] p;
        k = ph / SLOT;
        if (ph % SLOT < BC) return DARK_PINS;
        if (!dig_en[k]) return DARK_PINS;
        if (lz_suppress && k > 0 && (m_sh >> (4 * k)) == 16'h0) return DARK_PINS;
        p = seg_pins(4'(m_sh >> (4 * k)));
        if (m_sdp[k]) p[2] = 1'b1;
        p = p | DARK_PINS;
        p[COM_PIN[k] - 1] = 1'b0;
        return p;
    endfunction

    // Inputs only change just after posedge, so values seen here are what the next edge samples.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ph = 0; m_sh = '0; m_sdp = '0; m_pf = 0; m_ep = DARK_PINS; m_efd = 0;
                chk("reset_pins", 16'(pins), 16'(DARK_PINS));
                chk("reset_ready", 16'(val_ready), 16'd0);
                chk("reset_frame_done", 16'(frame_done), 16'd0);
            end else begin
                chk("pins", 16'(pins), 16'(m_ep));
                chk("frame_done", 16'(frame_done), 16'(m_efd));
                chk("val_ready", 16'(val_ready), 16'(!m_pf));
                acc = val_valid && !m_pf;
                if (m_ph == 0 && m_pf) begin
                    m_sh = m_pd; m_sdp = m_pdp; m_pf = 0;
                end
                if (acc) begin
                    m_pd = val_data; m_pdp = val_dp; m_pf = 1;
                end
                m_efd = (m_ph == FRAME - 1);
                m_ph  = (m_ph + 1) % FRAME;
                m_ep  = model_pins(m_ph);
            end
        end
    end

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0]       en;
        logic             lz;
        logic [3:0][11:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [6];

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!val_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_ready_timeout", 16'(n < 100), 16'd1);
        val_data = d; val_dp = dp; val_valid = 1'b1;
        @(posedge clk); #1;
        val_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, {12'h3E0, 12'hEB3, 12'hF72, 12'hBD8}};
        vecs[1] = '{16'h0007, 4'h0, 4'hF, 1'b1, {12'h9A0, 12'h9A0, 12'h9A0, 12'hFC8}};
        vecs[2] = '{16'h0100, 4'h0, 4'hF, 1'b1, {12'h9A0, 12'hAE0, 12'hF6B, 12'hFCB}};
        vecs[3] = '{16'h1234, 4'h1, 4'hE, 1'b0, {12'h3E0, 12'hEB3, 12'hF72, 12'h9A0}};
        vecs[4] = '{16'h000B, 4'h0, 4'hF, 1'b0, {12'h7EB, 12'hEEB, 12'hF6B, 12'h99B}};
        vecs[5] = '{16'h8888, 4'hA, 4'hF, 1'b0, {12'h7FF, 12'hEFB, 12'hF7F, 12'hFDB}};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("ready_after_release", 16'(val_ready), 16'd1);

        // Reset pulse in the middle of a digit slot
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("midrun_reset_pins", 16'(pins), 16'(DARK_PINS));
        chk("midrun_reset_ready", 16'(val_ready), 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("midrun_release_ready", 16'(val_ready), 16'd1);

        foreach (vecs[v]) begin
            @(posedge clk); #1;
            dig_en = vecs[v].en;
            lz_suppress = vecs[v].lz;
            load(vecs[v].data, vecs[v].dp);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_done && n < 60);
            chk("boundary_seen", 16'(n < 60), 16'd1);
            for (int c = 1; c <= FRAME; c++) begin
                @(negedge clk);
                if (c % SLOT == 3)
                    chk($sformatf("vec%0d_digit%0d", v, c / SLOT), 16'(pins), 16'(vecs[v].exp[c / SLOT]));
            end
            chk("frame_done_period", 16'(frame_done), 16'd1);
        end

        // Back-to-back loads: the second must stall until the frame boundary
        @(posedge clk); #1;
        dig_en = 4'hF; lz_suppress = 1'b0;
        load(16'hAAAA, 4'h0);
        val_data = 16'h5555; val_dp = 4'h0; val_valid = 1'b1;
        n = 0;
        while (!val_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("second_load_stalled", 16'(n > 0 && n < 100), 16'd1);
        @(posedge clk); #1;
        val_valid = 1'b0;
        repeat (2 * FRAME) @(posedge clk);

        // Randomized traffic; the model checks every cycle
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            dig_en      = 4'($urandom);
            lz_suppress = 1'($urandom);
            val_valid   = ($urandom_range(0, 5) == 0);
            val_data    = 16'($urandom >> (4 * $urandom_range(0, 4)));
            val_dp      = 4'($urandom);
        end
        @(posedge clk); #1;
        val_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
